// File: rtl/sync_fifo_pkg.sv
// Shared constants, sizing helper and status bundle for the parametrised synchronous FIFO.
// Optional first-word-fall-through read mode is selected with the SYNC_FIFO_FWFT_EN macro.
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
    function automatic int calc_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write port, asynchronous read address.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately left uninitialised; the pointers define what is valid.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through dout; otherwise dout is a registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = calc_cw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] rd_data;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the flags as they stand at the start of the cycle, so a
    // simultaneous wr/rd on an empty FIFO never reads the slot being written.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = wr & full;
        underflow_d = rd & empty;
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok & ~rst),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = empty ? '0 : rd_data;
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_ok) begin
            dout_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (8x16, AF_LVL=14, AE_LVL=2) against a queue-based model.
module tb_sync_fifo_param;
    import sync_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic [4:0]    count;
    logic          overflow, underflow;

    sync_fifo_param #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF),
        .AE_LVL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a plain queue plus the last word read out.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    logic          m_ov, m_un;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        int sz;
        if (rs) begin
            mq.delete();
            m_last = '0;
            m_ov   = 1'b0;
            m_un   = 1'b0;
        end else begin
            sz   = mq.size();
            m_ov = w && (sz == DEPTH);
            m_un = r && (sz == 0);
            if (r && sz > 0) m_last = mq.pop_front();
            if (w && sz < DEPTH) mq.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        fifo_status_t obs_st, exp_st;
        logic [DW-1:0] exp_dout;
        int sz;
        sz = mq.size();
        obs_st = '{full, empty, almost_full, almost_empty, overflow, underflow};
        exp_st = '{(sz == DEPTH), (sz == 0), (sz >= AF), (sz <= AE), m_ov, m_un};
`ifdef SYNC_FIFO_FWFT_EN
        exp_dout = (sz == 0) ? '0 : mq[0];
`else
        exp_dout = m_last;
`endif
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".status"}, 32'(obs_st), 32'(exp_st));
        chk({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    endtask

    // One clock: drive inputs, let the edge happen, then compare 1 time unit later.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d,
                        input logic rs = 1'b0);
        wr  = w;
        rd  = r;
        din = d;
        rst = rs;
        @(posedge clk);
        #1;
        model_step(w, r, d, rs);
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        m_last = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
        #1;
        step("reset0", 1'b0, 1'b0, 8'h00, 1'b1);
        step("reset1", 1'b0, 1'b0, 8'h00, 1'b1);
        step("idle", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 8'(i));
        step("overflow", 1'b1, 1'b0, 8'hAA);
        step("after_ovf", 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00);

        step("underflow", 1'b0, 1'b1, 8'h00);
        step("wr_rd_empty", 1'b1, 1'b1, 8'h55);
        step("read_55", 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 8; i++) step("to8", 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) step("wrrd8", 1'b1, 1'b1, 8'(8'h90 + i));
        for (int i = 0; i < 3; i++) step("to5", 1'b0, 1'b1, 8'h00);
        step("rst_mid", 1'b1, 1'b0, 8'hEE, 1'b1);
        step("post_rst_wr", 1'b1, 1'b0, 8'h77);
        step("post_rst_rd", 1'b0, 1'b1, 8'h00);

        step("fwft_wr", 1'b1, 1'b0, 8'h3C);
        step("fwft_hold", 1'b0, 1'b0, 8'h00);
        step("fwft_rd", 1'b0, 1'b1, 8'h00);

        // Randomised traffic in phases biased toward filling, draining and balanced use.
        for (int ph = 0; ph < 3; ph++) begin
            int wp, rp;
            wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            rp = 100 - wp;
            for (int i = 0; i < 120; i++) begin
                logic w, r, rs;
                w  = ($urandom_range(0, 99) < wp);
                r  = ($urandom_range(0, 99) < rp);
                rs = ($urandom_range(0, 99) == 0);
                step("rand", w, r, 8'($urandom), rs);
            end
        end

        wr = 1'b0;
        rd = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
